// File: rtl/iob_eth_rx_buf_ctrl_pkg.sv
// Shared definitions for the Ethernet RX ping-pong buffer controller.
package iob_eth_rx_buf_ctrl_pkg;

    // Write-side FSM states, 2-bit encoded.
    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_FILL = 2'b01,
        W_DROP = 2'b10
    } wr_state_t;

    // Shortest frame worth handing to the reader (bytes).
    localparam int ETH_MIN_LEN = 64;

endpackage

// File: rtl/iob_eth_sat_cnt.sv
// Saturating up-counter with synchronous reset; holds at all-ones.
module iob_eth_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    // Count one step per inc pulse until the counter is full.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/iob_eth_rx_buf_ctrl.sv
// Ping-pong controller for the RX frame buffer: steers receiver bytes into one
// of two banks, commits CRC-good frames, hands them to the reader in order and
// counts dropped frames.
module iob_eth_rx_buf_ctrl
    import iob_eth_rx_buf_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 8,
    parameter int MIN_LEN = ETH_MIN_LEN,
    parameter int CNT_W   = 16
) (
    input  logic              RX_CLK,
    input  logic              rst,
    input  logic              rx_sof,
    input  logic              rx_wr,
    input  logic [ADDR_W-1:0] rx_addr,
    input  logic [DATA_W-1:0] rx_wdata,
    input  logic              rx_eof,
    input  logic              rx_crc_ok,
    output logic              rx_ready,
    output logic              mem_wr,
    output logic [ADDR_W:0]   mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              frame_avail,
    output logic              frame_bank,
    output logic [ADDR_W:0]   frame_len,
    input  logic              frame_ack,
    output logic              frameReceived,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam int LEN_W = ADDR_W + 1;

    wr_state_t                   state_q, state_d;
    logic [1:0]                  full_q, full_d;
    logic [1:0][LEN_W-1:0]       len_q, len_d;
    logic [LEN_W-1:0]            cur_len_q, cur_len_d;
    logic                        wr_bank_q, wr_bank_d;
    logic                        rd_bank_q, rd_bank_d;
    logic                        frame_rcv_q, frame_rcv_d;
    logic                        drop_inc;

    logic [LEN_W-1:0]            wr_end;
    logic [LEN_W-1:0]            wr_len;
    logic                        len_ok;

    // Frame length including a write landing in the same cycle as rx_eof.
    assign wr_end = {1'b0, rx_addr} + LEN_W'(1);
    assign wr_len = (rx_wr && (wr_end > cur_len_q)) ? wr_end : cur_len_q;
    assign len_ok = (wr_len >= LEN_W'(MIN_LEN));

    // Next-state logic for the write FSM, bank status and read pointer.
    always_comb begin
        state_d     = state_q;
        full_d      = full_q;
        len_d       = len_q;
        cur_len_d   = cur_len_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        frame_rcv_d = 1'b0;
        drop_inc    = 1'b0;
        rx_ready    = 1'b0;
        mem_wr      = 1'b0;

        // Release acts only on the read bank, which can never be the bank
        // being committed, so it is applied independently of the write side.
        if (frame_ack && full_q[rd_bank_q]) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end

        case (state_q)
            W_IDLE: begin
                rx_ready = ~full_q[wr_bank_q];
                if (rx_sof) begin
                    cur_len_d = '0;
                    state_d   = full_q[wr_bank_q] ? W_DROP : W_FILL;
                end
            end
            W_FILL: begin
                mem_wr = rx_wr;
                if (rx_wr) begin
                    cur_len_d = wr_len;
                end
                if (rx_sof) begin
                    drop_inc  = 1'b1;
                    cur_len_d = '0;
                end else if (rx_eof) begin
                    if (rx_crc_ok && len_ok) begin
                        full_d[wr_bank_q] = 1'b1;
                        len_d[wr_bank_q]  = wr_len;
                        wr_bank_d         = ~wr_bank_q;
                        frame_rcv_d       = 1'b1;
                    end else begin
                        drop_inc = 1'b1;
                    end
                    state_d = W_IDLE;
                end
            end
            W_DROP: begin
                if (rx_eof) begin
                    drop_inc = 1'b1;
                    state_d  = W_IDLE;
                end
            end
            default: begin
                state_d = W_IDLE;
            end
        endcase
    end

    // State registers; reset discards any frame in progress without counting it.
    always_ff @(posedge RX_CLK) begin
        if (rst) begin
            state_q     <= W_IDLE;
            full_q      <= '0;
            len_q       <= '0;
            cur_len_q   <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            frame_rcv_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            full_q      <= full_d;
            len_q       <= len_d;
            cur_len_q   <= cur_len_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            frame_rcv_q <= frame_rcv_d;
        end
    end

    iob_eth_sat_cnt #(
        .W(CNT_W)
    ) u_drop_cnt (
        .clk (RX_CLK),
        .rst (rst),
        .inc (drop_inc),
        .cnt (drop_cnt)
    );

    assign mem_addr      = {wr_bank_q, rx_addr};
    assign mem_wdata     = rx_wdata;
    assign frame_bank    = rd_bank_q;
    assign frame_avail   = full_q[rd_bank_q];
    assign frame_len     = len_q[rd_bank_q];
    assign frameReceived = frame_rcv_q;

endmodule

// File: tb/tb_iob_eth_rx_buf_ctrl.sv
// Self-checking bench for iob_eth_rx_buf_ctrl: directed cases plus random
// frame/ack traffic checked against a queue-based model of committed frames.
module tb_iob_eth_rx_buf_ctrl;

    logic        RX_CLK = 1'b0;
    logic        rst;
    logic        rx_sof, rx_wr, rx_eof, rx_crc_ok, frame_ack;
    logic [10:0] rx_addr;
    logic [7:0]  rx_wdata;
    logic        rx_ready, mem_wr, frame_avail, frame_bank, frameReceived;
    logic [11:0] mem_addr, frame_len;
    logic [7:0]  mem_wdata;
    logic [15:0] drop_cnt;

    int errors = 0;
    int checks = 0;

    // Model: committed frames waiting for the reader, oldest first.
    int qLen[$];
    int qBank[$];
    int commits = 0;
    int dropCnt = 0;

    iob_eth_rx_buf_ctrl dut (
        .RX_CLK        (RX_CLK),
        .rst           (rst),
        .rx_sof        (rx_sof),
        .rx_wr         (rx_wr),
        .rx_addr       (rx_addr),
        .rx_wdata      (rx_wdata),
        .rx_eof        (rx_eof),
        .rx_crc_ok     (rx_crc_ok),
        .rx_ready      (rx_ready),
        .mem_wr        (mem_wr),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .frame_avail   (frame_avail),
        .frame_bank    (frame_bank),
        .frame_len     (frame_len),
        .frame_ack     (frame_ack),
        .frameReceived (frameReceived),
        .drop_cnt      (drop_cnt)
    );

    always #5 RX_CLK = ~RX_CLK;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs on the falling edge; caller samples 1 ns later.
    task automatic applyStimulus(input logic sof, input logic wr, input int addr,
                                 input logic [7:0] data, input logic eof,
                                 input logic crc, input logic ack);
        @(negedge RX_CLK);
        rx_sof    = sof;
        rx_wr     = wr;
        rx_addr   = 11'(addr);
        rx_wdata  = data;
        rx_eof    = eof;
        rx_crc_ok = crc;
        frame_ack = ack;
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    // Model update at end of frame, optionally with a simultaneous reader ack.
    task automatic endOfFrame(input bit acc, input bit crc, input int n,
                              input bit ackNow, output bit committed);
        if (ackNow) begin
            checkOutput("avail_at_eof", frame_avail, qLen.size() > 0);
            if (qLen.size() > 0) begin
                checkOutput("len_at_eof", frame_len, qLen[0]);
                void'(qLen.pop_front());
                void'(qBank.pop_front());
            end
        end
        committed = acc && crc && (n >= 64);
        if (committed) begin
            qLen.push_back(n);
            qBank.push_back(commits % 2);
            commits++;
        end else begin
            dropCnt++;
        end
    endtask

    // One received frame: sof, n writes at offsets 0..n-1, eof.
    task automatic sendFrame(input int n, input bit crc, input bit eofWithWrite,
                             input int abortAt, input bit ackWithEof);
        bit acc;
        bit committed;
        logic [7:0] d;
        logic [11:0] expAddr;
        acc = (qLen.size() < 2);
        checkOutput("rx_ready_pre", rx_ready, acc);
        applyStimulus(1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0);
        idleCycle();
        checkOutput("rx_ready_busy", rx_ready, 1'b0);
        if (abortAt > 0) begin
            for (int i = 0; i < abortAt; i++) begin
                applyStimulus(1'b0, 1'b1, i, 8'($urandom), 1'b0, 1'b0, 1'b0);
            end
            applyStimulus(1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0);
            if (acc) dropCnt++;
        end
        committed = 1'b0;
        for (int i = 0; i < n; i++) begin
            bit last;
            last = (i == n - 1) && eofWithWrite;
            d = 8'($urandom);
            applyStimulus(1'b0, 1'b1, i, d, last, crc, last && ackWithEof);
            checkOutput("mem_wr", mem_wr, acc);
            if (acc) begin
                expAddr = {1'(commits % 2), 11'(i)};
                checkOutput("mem_addr", mem_addr, expAddr);
                checkOutput("mem_wdata", mem_wdata, d);
            end
            if (last) endOfFrame(acc, crc, n, ackWithEof, committed);
        end
        if (!eofWithWrite) begin
            applyStimulus(1'b0, 1'b0, 0, 8'h00, 1'b1, crc, ackWithEof);
            checkOutput("mem_wr_eof", mem_wr, 1'b0);
            endOfFrame(acc, crc, n, ackWithEof, committed);
        end
        idleCycle();
        checkOutput("frameReceived", frameReceived, committed);
        checkOutput("drop_cnt", drop_cnt, dropCnt);
        checkOutput("rx_ready_post", rx_ready, qLen.size() < 2);
        idleCycle();
        checkOutput("frameReceived_1cyc", frameReceived, 1'b0);
    endtask

    // Reader acknowledges (or tries to) the oldest frame.
    task automatic ackFrame();
        applyStimulus(1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("frame_avail", frame_avail, qLen.size() > 0);
        if (qLen.size() > 0) begin
            checkOutput("frame_bank", frame_bank, qBank[0]);
            checkOutput("frame_len", frame_len, qLen[0]);
            void'(qLen.pop_front());
            void'(qBank.pop_front());
        end
        idleCycle();
    endtask

    task automatic checkResetState();
        checkOutput("rst_rx_ready", rx_ready, 1'b1);
        checkOutput("rst_frame_avail", frame_avail, 1'b0);
        checkOutput("rst_frame_bank", frame_bank, 1'b0);
        checkOutput("rst_frame_len", frame_len, 0);
        checkOutput("rst_drop_cnt", drop_cnt, 0);
        checkOutput("rst_frameReceived", frameReceived, 1'b0);
        checkOutput("rst_mem_wr", mem_wr, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        rx_sof = 0; rx_wr = 0; rx_addr = 0; rx_wdata = 0;
        rx_eof = 0; rx_crc_ok = 0; frame_ack = 0;
        repeat (3) idleCycle();
        rst = 1'b0;
        idleCycle();
        checkResetState();

        // Writes outside a frame must not reach the RAM.
        applyStimulus(1'b0, 1'b1, 5, 8'hA5, 1'b0, 1'b0, 1'b0);
        checkOutput("wr_in_idle", mem_wr, 1'b0);

        // Minimum-length good frame, then release it.
        sendFrame(64, 1, 1, 0, 0);
        ackFrame();

        // Two frames fill both banks; a third is dropped; reader drains in order.
        sendFrame(100, 1, 0, 0, 0);
        sendFrame(80, 1, 1, 0, 0);
        sendFrame(70, 1, 0, 0, 0);
        ackFrame();
        ackFrame();
        ackFrame();

        // Bad CRC, runt frames (60 and 63 bytes).
        sendFrame(100, 0, 0, 0, 0);
        sendFrame(60, 1, 1, 0, 0);
        sendFrame(63, 1, 1, 0, 0);

        // Aborted frame restarted in the same bank.
        sendFrame(70, 1, 0, 30, 0);
        ackFrame();

        // Commit in one bank while the other bank is acknowledged.
        sendFrame(90, 1, 0, 0, 0);
        sendFrame(75, 1, 1, 0, 1);
        ackFrame();

        // Reset in the middle of a frame.
        sendFrame(66, 1, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, i, 8'(i), 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        idleCycle();
        idleCycle();
        rst = 1'b0;
        qLen.delete();
        qBank.delete();
        commits = 0;
        dropCnt = 0;
        checkResetState();
        sendFrame(65, 1, 1, 0, 0);
        ackFrame();

        // Random traffic.
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 9) < 7) begin
                sendFrame($urandom_range(40, 130), $urandom_range(0, 9) < 8,
                          1'($urandom), ($urandom_range(0, 9) == 0) ? 12 : 0,
                          $urandom_range(0, 4) == 0);
            end else begin
                ackFrame();
            end
        end
        while (qLen.size() > 0) ackFrame();
        ackFrame();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
